// File: rtl/linear_mac_seq_if.sv
// linear_mac_seq_if: control, RAM-read and result-write signals of linear_mac_seq.
// b_addr/b_rdata exist only when LINEAR_BIAS_EN is defined.
interface linear_mac_seq_if #(
   parameter int unsigned DW   = 32,
   parameter int unsigned ROWS = 50,
   parameter int unsigned K    = 20,
   parameter int unsigned COLS = 20
);
   localparam int unsigned IAW = (ROWS * K > 1) ? $clog2(ROWS * K) : 1;
   localparam int unsigned WAW = (K * COLS > 1) ? $clog2(K * COLS) : 1;
   localparam int unsigned OAW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
   localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;

   logic           start;
   logic           busy;
   logic           done;
   logic [IAW-1:0] in_addr;
   logic [DW-1:0]  in_rdata;
   logic [WAW-1:0] w_addr;
   logic [DW-1:0]  w_rdata;
`ifdef LINEAR_BIAS_EN
   logic [CW-1:0]  b_addr;
   logic [DW-1:0]  b_rdata;
`endif
   logic           out_we;
   logic [OAW-1:0] out_addr;
   logic [DW-1:0]  out_data;

   modport master (
      input  start, in_rdata, w_rdata,
`ifdef LINEAR_BIAS_EN
      input  b_rdata,
      output b_addr,
`endif
      output busy, done, in_addr, w_addr, out_we, out_addr, out_data
   );

   modport slave (
      output start, in_rdata, w_rdata,
`ifdef LINEAR_BIAS_EN
      output b_rdata,
      input  b_addr,
`endif
      input  busy, done, in_addr, w_addr, out_we, out_addr, out_data
   );
endinterface

// File: rtl/linear_mac_seq.sv
// linear_mac_seq: sequential fixed-point linear layer OUT = sat((IN x W) >>> FRAC), one MAC per cycle
// over 1-cycle-latency RAMs. Define LINEAR_BIAS_EN to add a per-column bias (b_addr/b_rdata).
module linear_mac_seq #(
   parameter int unsigned DW   = 32,
   parameter int unsigned ROWS = 50,
   parameter int unsigned K    = 20,
   parameter int unsigned COLS = 20,
   parameter int unsigned FRAC = 24
) (
   input logic              clk,
   input logic              rst_n,
   linear_mac_seq_if.master bus
);
   localparam int unsigned IAW = (ROWS * K > 1) ? $clog2(ROWS * K) : 1;
   localparam int unsigned WAW = (K * COLS > 1) ? $clog2(K * COLS) : 1;
   localparam int unsigned OAW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
   localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned AW  = 2 * DW + $clog2(K) + 1;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_FIN} state_t;

   state_t                state, state_d;
   logic [KW-1:0]         k, k_d;
   logic [CW-1:0]         c, c_d, c_inc;
   logic [RW-1:0]         r, r_d;
   logic [IAW-1:0]        row_base, row_base_d, in_addr, in_addr_d;
   logic [WAW-1:0]        w_addr, w_addr_d;
   logic [CW-1:0]         b_addr, b_addr_d;
   logic [OAW-1:0]        out_addr, out_addr_d;
   logic [DW-1:0]         out_data, out_data_d;
   logic                  out_we, out_we_d, busy, busy_d, done, done_d;
   logic                  pend_vld, pend_vld_d, pend_first, pend_first_d;
   logic signed [AW-1:0]  acc, acc_d, acc_init, sh;
   logic signed [2*DW-1:0] prod;
   logic [DW-1:0]         sat_val;

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.in_addr  = in_addr;
   assign bus.w_addr   = w_addr;
   assign bus.out_we   = out_we;
   assign bus.out_addr = out_addr;
   assign bus.out_data = out_data;
`ifdef LINEAR_BIAS_EN
   assign bus.b_addr   = b_addr;
   assign acc_init     = AW'($signed(bus.b_rdata)) <<< FRAC;
`else
   assign acc_init     = '0;
`endif

   assign prod  = $signed(bus.in_rdata) * $signed(bus.w_rdata);
   assign c_inc = c + CW'(1);

   // Next state, counters, accumulator and registered outputs
   always_comb begin
      state_d      = state;
      k_d          = k;
      c_d          = c;
      r_d          = r;
      row_base_d   = row_base;
      in_addr_d    = in_addr;
      w_addr_d     = w_addr;
      b_addr_d     = b_addr;
      out_addr_d   = out_addr;
      out_data_d   = out_data;
      out_we_d     = 1'b0;
      busy_d       = busy;
      done_d       = 1'b0;
      pend_vld_d   = (state == S_MAC);
      pend_first_d = (state == S_MAC) && (k == '0);
      acc_d        = acc;

      // Products trail their address by one cycle; the first one of an element seeds acc
      if (pend_vld) begin
         acc_d = pend_first ? (acc_init + AW'(prod)) : (acc + AW'(prod));
      end

      sh = acc_d >>> FRAC;
      if (sh > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
      else if (sh < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
      else                   sat_val = sh[DW-1:0];

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_MAC;
               busy_d     = 1'b1;
               k_d        = '0;
               c_d        = '0;
               r_d        = '0;
               row_base_d = '0;
               in_addr_d  = '0;
               w_addr_d   = '0;
               b_addr_d   = '0;
               out_addr_d = '0;
            end
         end
         S_MAC: begin
            if (k == KW'(K - 1)) begin
               state_d = S_DRAIN;
            end else begin
               k_d       = k + KW'(1);
               in_addr_d = in_addr + IAW'(1);
               w_addr_d  = w_addr + WAW'(COLS);
            end
         end
         S_DRAIN: begin
            state_d    = S_WRITE;
            out_we_d   = 1'b1;
            out_data_d = sat_val;
         end
         S_WRITE: begin
            k_d = '0;
            if (c == CW'(COLS - 1)) begin
               c_d = '0;
               if (r == RW'(ROWS - 1)) begin
                  state_d = S_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_MAC;
                  r_d        = r + RW'(1);
                  row_base_d = row_base + IAW'(K);
                  in_addr_d  = row_base + IAW'(K);
                  w_addr_d   = '0;
                  b_addr_d   = '0;
                  out_addr_d = out_addr + OAW'(1);
               end
            end else begin
               state_d    = S_MAC;
               c_d        = c_inc;
               in_addr_d  = row_base;
               w_addr_d   = WAW'(c_inc);
               b_addr_d   = c_inc;
               out_addr_d = out_addr + OAW'(1);
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         k          <= '0;
         c          <= '0;
         r          <= '0;
         row_base   <= '0;
         in_addr    <= '0;
         w_addr     <= '0;
         b_addr     <= '0;
         out_addr   <= '0;
         out_data   <= '0;
         out_we     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pend_vld   <= 1'b0;
         pend_first <= 1'b0;
         acc        <= '0;
      end else begin
         state      <= state_d;
         k          <= k_d;
         c          <= c_d;
         r          <= r_d;
         row_base   <= row_base_d;
         in_addr    <= in_addr_d;
         w_addr     <= w_addr_d;
         b_addr     <= b_addr_d;
         out_addr   <= out_addr_d;
         out_data   <= out_data_d;
         out_we     <= out_we_d;
         busy       <= busy_d;
         done       <= done_d;
         pend_vld   <= pend_vld_d;
         pend_first <= pend_first_d;
         acc        <= acc_d;
      end
   end
endmodule

// File: tb/tb_linear_mac_seq.sv
// tb_linear_mac_seq: scoreboard bench for linear_mac_seq with a 3x4x5 instance and a K=1 instance.
module tb_linear_mac_seq;
   localparam int unsigned DW     = 32;
   localparam int unsigned FRAC   = 24;
   localparam int unsigned ROWS_A = 3;
   localparam int unsigned K_A    = 4;
   localparam int unsigned COLS_A = 5;
   localparam int unsigned ROWS_B = 2;
   localparam int unsigned K_B    = 1;
   localparam int unsigned COLS_B = 3;
   localparam int CYC_A  = 1 + ROWS_A * COLS_A * (K_A + 2);
   localparam int CYC_B  = 1 + ROWS_B * COLS_B * (K_B + 2);
   localparam int BUDGET = 400;
   localparam logic signed [127:0] SMAX = 128'sh7FFFFFFF;
   localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;

   typedef struct {
      int            addr;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic [DW-1:0] in_mem [64];
   logic [DW-1:0] w_mem  [64];
`ifdef LINEAR_BIAS_EN
   logic [DW-1:0] b_mem  [64];
`endif

   always #5 clk = ~clk;

   linear_mac_seq_if #(.DW(DW), .ROWS(ROWS_A), .K(K_A), .COLS(COLS_A)) bus_a ();
   linear_mac_seq_if #(.DW(DW), .ROWS(ROWS_B), .K(K_B), .COLS(COLS_B)) bus_b ();

   linear_mac_seq #(.DW(DW), .ROWS(ROWS_A), .K(K_A), .COLS(COLS_A), .FRAC(FRAC)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   linear_mac_seq #(.DW(DW), .ROWS(ROWS_B), .K(K_B), .COLS(COLS_B), .FRAC(FRAC)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   // Synchronous-read RAM models shared by both instances
   always @(posedge clk) begin
      bus_a.in_rdata <= in_mem[bus_a.in_addr];
      bus_a.w_rdata  <= w_mem[bus_a.w_addr];
      bus_b.in_rdata <= in_mem[bus_b.in_addr];
      bus_b.w_rdata  <= w_mem[bus_b.w_addr];
`ifdef LINEAR_BIAS_EN
      bus_a.b_rdata  <= b_mem[bus_a.b_addr];
      bus_b.b_rdata  <= b_mem[bus_b.b_addr];
`endif
   end

   // Scoreboard pop on every output write
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus_a.out_we) begin
         vectors++;
         if (q_a.size() == 0) begin
            miscompares++;
            $display("FAIL write_a unexpected addr=%0d data=%h, none expected", bus_a.out_addr, bus_a.out_data);
         end else begin
            e = q_a.pop_front();
            if (int'(bus_a.out_addr) !== e.addr || bus_a.out_data !== e.data) begin
               miscompares++;
               $display("FAIL write_a got addr=%0d data=%h expected addr=%0d data=%h",
                        bus_a.out_addr, bus_a.out_data, e.addr, e.data);
            end
         end
      end
      if (rst_n && bus_b.out_we) begin
         vectors++;
         if (q_b.size() == 0) begin
            miscompares++;
            $display("FAIL write_b unexpected addr=%0d data=%h, none expected", bus_b.out_addr, bus_b.out_data);
         end else begin
            e = q_b.pop_front();
            if (int'(bus_b.out_addr) !== e.addr || bus_b.out_data !== e.data) begin
               miscompares++;
               $display("FAIL write_b got addr=%0d data=%h expected addr=%0d data=%h",
                        bus_b.out_addr, bus_b.out_data, e.addr, e.data);
            end
         end
      end
   end

   function automatic logic [DW-1:0] ref_out(int kk, int cols, int r, int c);
      logic signed [127:0] acc, sh;
      acc = '0;
`ifdef LINEAR_BIAS_EN
      acc = 128'($signed(b_mem[c])) <<< FRAC;
`endif
      for (int k = 0; k < kk; k++)
         acc += 128'($signed(in_mem[r*kk+k])) * 128'($signed(w_mem[k*cols+c]));
      sh = acc >>> FRAC;
      if (sh > SMAX) return 32'h7FFFFFFF;
      if (sh < SMIN) return 32'h80000000;
      return sh[DW-1:0];
   endfunction

   task automatic fill(input logic [DW-1:0] iv, input logic [DW-1:0] wv);
      for (int i = 0; i < 64; i++) begin
         in_mem[i] = iv;
         w_mem[i]  = wv;
`ifdef LINEAR_BIAS_EN
         b_mem[i]  = '0;
`endif
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < 64; i++) begin
         in_mem[i] = $urandom();
         w_mem[i]  = $urandom();
`ifdef LINEAR_BIAS_EN
         b_mem[i]  = $urandom();
`endif
      end
   endtask

   task automatic push_model_a();
      for (int r = 0; r < int'(ROWS_A); r++)
         for (int c = 0; c < int'(COLS_A); c++)
            q_a.push_back('{addr: r*COLS_A + c, data: ref_out(K_A, COLS_A, r, c)});
   endtask

   task automatic push_const_a(input logic [DW-1:0] v);
      for (int i = 0; i < int'(ROWS_A * COLS_A); i++) q_a.push_back('{addr: i, data: v});
   endtask

   // mode 0: one-cycle start, 1: start held, 2: extra start pulse mid-run; abort_at>0 drops rst_n then
   task automatic run_a(input int mode, input int abort_at, output int cycles, output bit timed_out,
                        output bit busy_ok);
      int edges;
      edges = 0; cycles = 0; timed_out = 1'b1; busy_ok = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      if (mode != 1) bus_a.start = 1'b0;
      while (edges < BUDGET) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (mode == 2) bus_a.start = (edges == 20);
         if (abort_at > 0 && edges == abort_at) begin
            rst_n = 1'b0;
            timed_out = 1'b0;
            cycles = edges;
            break;
         end
         if (bus_a.done === 1'b1) begin
            if (bus_a.busy !== 1'b0) busy_ok = 1'b0;
            cycles = edges + 1;
            timed_out = 1'b0;
            bus_a.start = 1'b0;
            break;
         end
         if (bus_a.busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus_a.busy, bus_a.done, bus_a.out_we} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_ctrl busy/done/we=%b expected 000", {bus_a.busy, bus_a.done, bus_a.out_we});
      end
      vectors++;
      if (bus_a.in_addr !== '0 || bus_a.w_addr !== '0 || bus_a.out_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_addr in=%0d w=%0d out=%0d expected 0", bus_a.in_addr, bus_a.w_addr, bus_a.out_addr);
      end
      vectors++;
      if (bus_a.out_data !== '0) begin
         miscompares++;
         $display("FAIL reset_data out_data=%h expected 0", bus_a.out_data);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus_a.busy, bus_b.busy, bus_a.out_we} !== 3'b000) begin
         miscompares++;
         $display("FAIL idle_no_start busy_a/busy_b/we=%b expected 000", {bus_a.busy, bus_b.busy, bus_a.out_we});
      end
   endtask

   task automatic test_identity();
      int cyc; bit to, bok;
      fill('0, '0);
      for (int r = 0; r < int'(ROWS_A); r++)
         for (int k = 0; k < int'(K_A); k++) in_mem[r*K_A + k] = 32'((r + k) << 24);
      for (int k = 0; k < int'(K_A); k++) w_mem[k*COLS_A + k] = 32'h0100_0000;
      for (int r = 0; r < int'(ROWS_A); r++)
         for (int c = 0; c < int'(COLS_A); c++)
            q_a.push_back('{addr: r*COLS_A + c, data: (c < int'(K_A)) ? 32'((r + c) << 24) : 32'h0});
      run_a(0, 0, cyc, to, bok);
      vectors++;
      if (to || cyc != CYC_A) begin
         miscompares++;
         $display("FAIL identity_latency cycles=%0d timeout=%0d expected %0d", cyc, to, CYC_A);
      end
      vectors++;
      if (!bok) begin miscompares++; $display("FAIL identity_busy busy_ok=0 expected 1"); end
      @(negedge clk);
      vectors++;
      if (q_a.size() != 0 || bus_a.done !== 1'b0) begin
         miscompares++;
         $display("FAIL identity_drain pending=%0d done=%b expected 0 0", q_a.size(), bus_a.done);
      end
   endtask

   task automatic test_saturation();
      int cyc; bit to, bok;
      for (int pass = 0; pass < 2; pass++) begin
         fill(32'h7FFFFFFF, (pass == 0) ? 32'h7FFFFFFF : 32'h80000000);
         push_const_a((pass == 0) ? 32'h7FFFFFFF : 32'h80000000);
         run_a(0, 0, cyc, to, bok);
         @(negedge clk);
         vectors++;
         if (to || cyc != CYC_A || q_a.size() != 0) begin
            miscompares++;
            $display("FAIL saturation_%0d cycles=%0d pending=%0d expected %0d 0", pass, cyc, q_a.size(), CYC_A);
         end
      end
   endtask

   task automatic test_neg_shift();
      int cyc; bit to, bok;
      fill('0, '0);
      for (int r = 0; r < int'(ROWS_A); r++) in_mem[r*K_A] = 32'hFFFFFFFF;
      for (int c = 0; c < int'(COLS_A); c++) w_mem[c] = 32'h1;
      push_const_a(32'hFFFFFFFF);
      run_a(0, 0, cyc, to, bok);
      @(negedge clk);
      vectors++;
      if (to || cyc != CYC_A || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL neg_shift cycles=%0d pending=%0d expected %0d 0", cyc, q_a.size(), CYC_A);
      end
   endtask

   task automatic test_start_ignore();
      int cyc; bit to, bok;
      for (int mode = 1; mode <= 2; mode++) begin
         load_random();
         push_model_a();
         run_a(mode, 0, cyc, to, bok);
         vectors++;
         if (to || cyc != CYC_A || !bok) begin
            miscompares++;
            $display("FAIL start_ignore_%0d cycles=%0d busy_ok=%0d expected %0d 1", mode, cyc, bok, CYC_A);
         end
         repeat (6) begin
            @(negedge clk);
            vectors++;
            if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
               miscompares++;
               $display("FAIL no_restart_%0d busy=%b done=%b expected 0 0", mode, bus_a.busy, bus_a.done);
            end
         end
         vectors++;
         if (q_a.size() != 0) begin
            miscompares++;
            $display("FAIL start_ignore_%0d_pending got %0d expected 0", mode, q_a.size());
         end
      end
   endtask

   task automatic test_reset_abort();
      int cyc; bit to, bok;
      load_random();
      push_model_a();
      run_a(0, 40, cyc, to, bok);
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if ({bus_a.busy, bus_a.done, bus_a.out_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_in_reset busy/done/we=%b expected 000", {bus_a.busy, bus_a.done, bus_a.out_we});
         end
      end
      q_a.delete();
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         vectors++;
         if ({bus_a.busy, bus_a.done, bus_a.out_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_after busy/done/we=%b expected 000", {bus_a.busy, bus_a.done, bus_a.out_we});
         end
      end
      load_random();
      push_model_a();
      run_a(0, 0, cyc, to, bok);
      @(negedge clk);
      vectors++;
      if (to || cyc != CYC_A || !bok || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL abort_rerun cycles=%0d busy_ok=%0d pending=%0d expected %0d 1 0", cyc, bok, q_a.size(), CYC_A);
      end
   endtask

   task automatic test_k1();
      int edges, cyc;
      load_random();
      for (int r = 0; r < int'(ROWS_B); r++)
         for (int c = 0; c < int'(COLS_B); c++)
            q_b.push_back('{addr: r*COLS_B + c, data: ref_out(K_B, COLS_B, r, c)});
      edges = 0; cyc = 0;
      @(negedge clk);
      bus_b.start = 1'b1;
      @(posedge clk);
      #1 bus_b.start = 1'b0;
      while (edges < BUDGET) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (bus_b.done === 1'b1) begin
            cyc = edges + 1;
            break;
         end
      end
      @(negedge clk);
      vectors++;
      if (cyc != CYC_B || q_b.size() != 0) begin
         miscompares++;
         $display("FAIL k1_run cycles=%0d pending=%0d expected %0d 0", cyc, q_b.size(), CYC_B);
      end
   endtask

`ifdef LINEAR_BIAS_EN
   task automatic test_bias();
      int cyc; bit to, bok;
      load_random();
      for (int i = 0; i < 64; i++) begin
         w_mem[i] = '0;
         b_mem[i] = 32'(i);
      end
      for (int r = 0; r < int'(ROWS_A); r++)
         for (int c = 0; c < int'(COLS_A); c++) q_a.push_back('{addr: r*COLS_A + c, data: 32'(c)});
      run_a(0, 0, cyc, to, bok);
      @(negedge clk);
      vectors++;
      if (to || cyc != CYC_A || q_a.size() != 0) begin
         miscompares++;
         $display("FAIL bias cycles=%0d pending=%0d expected %0d 0", cyc, q_a.size(), CYC_A);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      fill('0, '0);
      test_reset();
      test_identity();
      test_saturation();
      test_neg_shift();
      test_start_ignore();
      test_reset_abort();
      test_k1();
`ifdef LINEAR_BIAS_EN
      test_bias();
`endif
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
